freq_div_ctrl: RTL and testbench

Runtime-configurable clock-divider controller for the pattern generator. It sequences a half-period counter to produce a divided square wave `freq_2` and a one-cycle rising-edge strobe from the board clock. It accepts new divisors through a valid/ready handshake and applies them only at period boundaries, so no output period is ever truncated. It starts and stops the output cleanly under a `run` enable and sits between the control registers and every block that needs a programmable rate.

---
 rtl/pig_clk_pkg.sv | 29 ++
 rtl/freq_div_ctrl_if.sv | 27 ++
 rtl/half_period_counter.sv | 35 +++
 rtl/freq_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_freq_div_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pig_clk_pkg.sv
// Shared definitions for the programmable clock-divider blocks:
// controller state encoding, default counter width and the
// half-period helper used to derive power-up divisors.
package pig_clk_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Half-period in input clocks for a square wave of out_hz; never below 1
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned out_hz);
    int unsigned h;
    if (out_hz == 0) begin
      h = 1;
    end else begin
      h = clk_hz / (out_hz * 32'd2);
    end
    if (h == 0) begin
      h = 1;
    end
    return h;
  endfunction

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Divisor configuration channel: valid/ready transfer of a new half-period
// plus the controller's acknowledge and error pulses.
interface freq_div_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_ack,
    output cfg_err
  );
endinterface

// File: rtl/half_period_counter.sv
// Loadable up-counter that runs 0..half-1 and flags the terminal count.
// The count wraps to 0 by itself after the terminal cycle.
module half_period_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  input  logic [CNT_W-1:0] half,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Terminal count is a plain compare; the owner decides when it matters
  assign tc = (cnt == (half - CNT_W'(1)));

  // Load has priority over counting; wrap to 0 on terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Runtime-configurable clock divider controller. Produces a square wave
// (high half first) with a rising-edge strobe, accepts new divisors over a
// valid/ready channel and only swaps them in at period boundaries so no
// output period is ever cut short. Stopping lets the current period finish.
module freq_div_ctrl
  import pig_clk_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TARGET_FREQ = 480_000,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk_freq1,
  input  logic             rst_n_key1,
  input  logic             run,
  freq_div_ctrl_if.slave   cfg,
  output logic             freq_2,
  output logic             tick,
  output logic [CNT_W-1:0] active_half
);

  localparam int unsigned      DIV_DEFAULT_I = half_period(CLK_FREQ, TARGET_FREQ);
  localparam logic [CNT_W-1:0] DIV_DEFAULT   = CNT_W'(DIV_DEFAULT_I);

  state_t           state;
  logic             ready_r;
  logic             ack_r;
  logic             err_r;
  logic             pend_vld;
  logic [CNT_W-1:0] pend_half;

  logic             tc;
  logic             idle;
  logic             xfer;
  logic             zero_offer;
  logic             hi_end;
  logic             low_end;
  logic             rise;
  logic             to_idle;
  logic             apply_now;
  logic [CNT_W-1:0] new_half;

  assign cfg.cfg_ready = ready_r;
  assign cfg.cfg_ack   = ack_r;
  assign cfg.cfg_err   = err_r;

  // Counter is parked at 0 while idle so the first high half is full length
  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_half_cnt (
    .clk    (clk_freq1),
    .rst_n  (rst_n_key1),
    .ld     (idle),
    .ld_val ('0),
    .en     (!idle),
    .half   (active_half),
    .tc     (tc)
  );

  // Next-edge decode: half ends, boundary (rise), stop completion, divisor swap.
  // A transfer that lands on the edge creating a boundary is applied at once,
  // since that boundary is still strictly after the transfer cycle.
  always_comb begin
    idle       = (state == ST_IDLE);
    xfer       = cfg.cfg_valid && ready_r && (cfg.cfg_half != '0);
    zero_offer = cfg.cfg_valid && ready_r && (cfg.cfg_half == '0);
    hi_end     = !idle && freq_2 && tc;
    low_end    = !idle && !freq_2 && tc;
    rise       = (idle && run) || (low_end && run);
    to_idle    = low_end && !run;
    apply_now  = (idle || rise || to_idle) && (pend_vld || xfer);
    new_half   = pend_vld ? pend_half : cfg.cfg_half;
  end

  // Control FSM with registered outputs, handshake and divisor application
  always_ff @(posedge clk_freq1 or negedge rst_n_key1) begin
    if (!rst_n_key1) begin
      state       <= ST_IDLE;
      freq_2      <= 1'b0;
      tick        <= 1'b0;
      ready_r     <= 1'b1;
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      pend_vld    <= 1'b0;
      active_half <= DIV_DEFAULT;
    end else begin
      tick  <= rise;
      ack_r <= apply_now;
      err_r <= zero_offer;

      if (apply_now) begin
        active_half <= new_half;
      end

      if (apply_now) begin
        pend_vld <= 1'b0;
      end else if (xfer) begin
        pend_vld <= 1'b1;
      end

      // Busy from the cycle after a transfer until the cycle after its ack
      if (xfer) begin
        ready_r <= 1'b0;
      end else if (ack_r) begin
        ready_r <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (run) begin
            state  <= ST_RUN;
            freq_2 <= 1'b1;
          end
        end
        ST_RUN, ST_STOP: begin
          if (hi_end) begin
            freq_2 <= 1'b0;
          end else if (rise) begin
            freq_2 <= 1'b1;
          end
          if (to_idle) begin
            state <= ST_IDLE;
          end else if (run) begin
            state <= ST_RUN;
          end else begin
            state <= ST_STOP;
          end
        end
        default: begin
          state  <= ST_IDLE;
          freq_2 <= 1'b0;
        end
      endcase
    end
  end

  // Offered divisor is held here until the next boundary
  always_ff @(posedge clk_freq1) begin
    if (xfer) begin
      pend_half <= cfg.cfg_half;
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: scenario tasks drive the controller, push the
// expected half-period lengths to a queue and pop them as halves complete.
module tb_freq_div_ctrl;

  localparam int CNT_W = 32;

  logic             clk_freq1;
  logic             rst_n_key1;
  logic             run;
  logic             freq_2;
  logic             tick;
  logic [CNT_W-1:0] active_half;

  freq_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

  freq_div_ctrl #(
    .CLK_FREQ    (50_000_000),
    .TARGET_FREQ (480_000),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_freq1   (clk_freq1),
    .rst_n_key1  (rst_n_key1),
    .run         (run),
    .cfg         (cfg_if),
    .freq_2      (freq_2),
    .tick        (tick),
    .active_half (active_half)
  );

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk_freq1 = 1'b0;
  always #5 clk_freq1 = ~clk_freq1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk_freq1);
  endtask

  task automatic push_exp(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Follow n halves of freq_2; the current cycle is already start_len cycles
  // into the first one. Each completed half is scored against the queue.
  task automatic follow_halves(input int n, input int start_len);
    int   len;
    logic f0;
    exp_t e;
    len = start_len;
    for (int i = 0; i < n; i++) begin
      f0 = freq_2;
      while (len < 600) begin
        step();
        if (freq_2 !== f0) break;
        len++;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got half of %0d with nothing expected", len);
      end else begin
        e = exp_q.pop_front();
        if (len != e.val) begin
          n_fail++;
          $display("FAIL %s: got %0d cycles expected %0d", e.name, len, e.val);
        end
      end
      if (freq_2 === 1'b1) begin
        n_tests++;
        if (tick !== 1'b1) begin
          n_fail++;
          $display("FAIL tick_at_rise: got %b expected 1", tick);
        end
      end
      len = 1;
    end
  endtask

  task automatic apply_reset();
    step();
    rst_n_key1       = 1'b0;
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    step();
    step();
    rst_n_key1 = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n_key1       = 1'b0;
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half  = '0;
    step();
    step();
    n_tests++;
    if ({freq_2, tick, cfg_if.cfg_ack, cfg_if.cfg_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected 0000", {freq_2, tick, cfg_if.cfg_ack, cfg_if.cfg_err});
    end
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready);
    end
    n_tests++;
    if (active_half !== 32'd52) begin
      n_fail++;
      $display("FAIL reset_half: got %0d expected 52", active_half);
    end
    rst_n_key1 = 1'b1;
    step();
  endtask

  task automatic test_default_run();
    run = 1'b1;
    step();
    n_tests++;
    if ({freq_2, tick} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_tick: got %b expected 11", {freq_2, tick});
    end
    step();
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_one_cycle: got %b expected 0", tick);
    end
    push_exp("default_high", 52);
    push_exp("default_low", 52);
    follow_halves(2, 2);
    n_tests++;
    if (active_half !== 32'd52) begin
      n_fail++;
      $display("FAIL default_active: got %0d expected 52", active_half);
    end
  endtask

  task automatic test_idle_cfg();
    apply_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd5;
    step();
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b1 || active_half !== 32'd5) begin
      n_fail++;
      $display("FAIL idle_apply: got ack %b half %0d expected ack 1 half 5", cfg_if.cfg_ack, active_half);
    end
    step();
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack_pulse: got %b expected 0", cfg_if.cfg_ack);
    end
    run = 1'b1;
    step();
    push_exp("h5_high", 5);
    push_exp("h5_low", 5);
    push_exp("h5_high", 5);
    push_exp("h5_low", 5);
    follow_halves(4, 1);
  endtask

  task automatic test_mid_change();
    step();
    step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd3;
    step();
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy: got ready %b ack %b expected ready 0 ack 0", cfg_if.cfg_ready, cfg_if.cfg_ack);
    end
    push_exp("mid_old_high", 5);
    push_exp("mid_old_low", 5);
    follow_halves(2, 4);
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b1 || active_half !== 32'd3 || cfg_if.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_boundary_ack: got ack %b half %0d ready %b expected ack 1 half 3 ready 0",
               cfg_if.cfg_ack, active_half, cfg_if.cfg_ready);
    end
    step();
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_ack: got ack %b ready %b expected ack 0 ready 1", cfg_if.cfg_ack, cfg_if.cfg_ready);
    end
    push_exp("h3_high", 3);
    push_exp("h3_low", 3);
    push_exp("h3_high", 3);
    push_exp("h3_low", 3);
    follow_halves(4, 2);
  endtask

  task automatic test_boundary_xfer();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b0 || active_half !== 32'd3) begin
      n_fail++;
      $display("FAIL bnd_wait: got ack %b half %0d expected ack 0 half 3", cfg_if.cfg_ack, active_half);
    end
    push_exp("bnd_old_high", 3);
    push_exp("bnd_old_low", 3);
    follow_halves(2, 2);
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b1 || active_half !== 32'd2) begin
      n_fail++;
      $display("FAIL bnd_apply: got ack %b half %0d expected ack 1 half 2", cfg_if.cfg_ack, active_half);
    end
    push_exp("h2_high", 2);
    push_exp("h2_low", 2);
    follow_halves(2, 1);
  endtask

  task automatic test_zero_cfg();
    step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = '0;
    step();
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_err: got err %b ready %b ack %b expected err 1 ready 1 ack 0",
               cfg_if.cfg_err, cfg_if.cfg_ready, cfg_if.cfg_ack);
    end
    step();
    n_tests++;
    if (cfg_if.cfg_err !== 1'b0 || active_half !== 32'd2) begin
      n_fail++;
      $display("FAIL zero_after: got err %b half %0d expected err 0 half 2", cfg_if.cfg_err, active_half);
    end
  endtask

  task automatic test_stop();
    int bad;
    apply_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    run = 1'b1;
    step();
    run              = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd6;
    step();
    cfg_if.cfg_valid = 1'b0;
    push_exp("stop_high", 4);
    follow_halves(1, 2);
    repeat (3) step();
    n_tests++;
    if (cfg_if.cfg_ack !== 1'b0 || freq_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_low_half: got ack %b freq %b expected 0 0", cfg_if.cfg_ack, freq_2);
    end
    step();
    n_tests++;
    if ({cfg_if.cfg_ack, tick, freq_2} !== 3'b100 || active_half !== 32'd6) begin
      n_fail++;
      $display("FAIL stop_idle_entry: got ack/tick/freq %b half %0d expected 100 half 6",
               {cfg_if.cfg_ack, tick, freq_2}, active_half);
    end
    bad = 0;
    repeat (12) begin
      step();
      if (freq_2 !== 1'b0 || tick !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stop_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_stop_resume();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd4;
    step();
    cfg_if.cfg_valid = 1'b0;
    step();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    push_exp("resume_high", 4);
    follow_halves(1, 2);
    step();
    run = 1'b1;
    push_exp("resume_low", 4);
    push_exp("resume_high2", 4);
    push_exp("resume_low2", 4);
    follow_halves(3, 2);
  endtask

  task automatic test_reset_pending();
    int bad;
    step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_half  = 32'd7;
    step();
    cfg_if.cfg_valid = 1'b0;
    n_tests++;
    if (cfg_if.cfg_ready !== 1'b0 || freq_2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got ready %b freq %b expected ready 0 freq 1", cfg_if.cfg_ready, freq_2);
    end
    rst_n_key1 = 1'b0;
    #1;
    n_tests++;
    if ({freq_2, tick, cfg_if.cfg_ack, cfg_if.cfg_ready} !== 4'b0001 || active_half !== 32'd52) begin
      n_fail++;
      $display("FAIL rst_async: got %b half %0d expected 0001 half 52",
               {freq_2, tick, cfg_if.cfg_ack, cfg_if.cfg_ready}, active_half);
    end
    run = 1'b0;
    step();
    step();
    rst_n_key1 = 1'b1;
    bad = 0;
    repeat (12) begin
      step();
      if (cfg_if.cfg_ack !== 1'b0 || freq_2 !== 1'b0 || tick !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || active_half !== 32'd52) begin
      n_fail++;
      $display("FAIL rst_discard: got %0d active cycles half %0d expected 0 half 52", bad, active_half);
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_mid_change();
    test_boundary_xfer();
    test_zero_cfg();
    test_stop();
    test_stop_resume();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
